// File: rtl/rgb_fade_seq.sv
// rgb_fade_seq: steps through a fixed 7-colour palette and linearly
// crossfades between neighbouring entries. The registered 8-bit R/G/B levels
// feed the downstream LED PWM stage. lvl_upd flags every level write.
//
// state | meaning
// ------+-------------------------------------------------------------
// HOLD  | current palette colour shown; count HOLD_STEPS step ticks
// FADE  | per tick, alpha += 1 and levels blend toward the next colour
module rgb_fade_seq #(
    parameter int STEP_DIV   = 390625,
    parameter int HOLD_STEPS = 256
) (
    input  logic       clk100mhz,
    input  logic       rst,
    input  logic       enable,
    input  logic       hold_only,
    input  logic       skip,
    output logic [7:0] red_lvl,
    output logic [7:0] green_lvl,
    output logic [7:0] blue_lvl,
    output logic [2:0] color_idx,
    output logic       lvl_upd
);

    localparam int PW = $clog2(STEP_DIV);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_STEPS - 1);

    typedef enum logic {S_HOLD = 1'b0, S_FADE = 1'b1} state_t;

    // Palette entries packed as {R,G,B}; index 7 is unreachable.
    function automatic logic [23:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    palette = {8'd255, 8'd0,   8'd0};
            3'd1:    palette = {8'd255, 8'd128, 8'd0};
            3'd2:    palette = {8'd255, 8'd255, 8'd0};
            3'd3:    palette = {8'd0,   8'd255, 8'd0};
            3'd4:    palette = {8'd0,   8'd0,   8'd255};
            3'd5:    palette = {8'd102, 8'd0,   8'd255};
            3'd6:    palette = {8'd128, 8'd0,   8'd128};
            default: palette = {8'd255, 8'd0,   8'd0};
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        next_idx = (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

    // (a*(256-alpha) + b*alpha) >> 8, truncated; the sum never exceeds 65280.
    function automatic logic [7:0] mix(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] alpha);
        logic [16:0] pa, pb, s;
        pa  = 17'(a) * (17'd256 - 17'(alpha));
        pb  = 17'(b) * 17'(alpha);
        s   = pa + pb;
        mix = s[15:8];
    endfunction

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [7:0]     alpha_q, alpha_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic           upd_q, upd_d;

    logic           tick, do_skip, hold_done, fade_done;
    logic [2:0]     nxt;
    logic [23:0]    pal_a, pal_b;
    logic [7:0]     alpha_inc;

    assign tick      = enable && (presc_q == PRESC_LAST);
    assign do_skip   = enable && skip;
    assign hold_done = tick && (state_q == S_HOLD) && (hold_q == HOLD_LAST);
    assign fade_done = tick && (state_q == S_FADE) && (alpha_q == 8'hFF);
    assign nxt       = next_idx(idx_q);
    assign pal_a     = palette(idx_q);
    assign pal_b     = palette(nxt);
    assign alpha_inc = alpha_q + 8'd1;

    // State and datapath registers; reset forces outputs without a clock.
    always_ff @(posedge clk100mhz or negedge rst) begin
        if (!rst) begin
            state_q <= S_HOLD;
            presc_q <= '0;
            hold_q  <= '0;
            alpha_q <= 8'd0;
            idx_q   <= 3'd0;
            red_q   <= 8'd255;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            alpha_q <= alpha_d;
            idx_q   <= idx_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            upd_q   <= upd_d;
        end
    end

    // Next-state selection; skip overrides any coincident tick.
    always_comb begin
        state_d = state_q;
        if (do_skip) begin
            state_d = S_HOLD;
        end else if (hold_done && !hold_only) begin
            state_d = S_FADE;
        end else if (fade_done) begin
            state_d = S_HOLD;
        end
    end

    // Counters, palette index and level updates for the current edge.
    always_comb begin
        presc_d = presc_q;
        hold_d  = hold_q;
        alpha_d = alpha_q;
        idx_d   = idx_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        upd_d   = 1'b0;

        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (do_skip) begin
            presc_d = '0;
            hold_d  = '0;
            alpha_d = 8'd0;
            idx_d   = nxt;
            {red_d, green_d, blue_d} = pal_b;
            upd_d   = 1'b1;
        end else if (tick) begin
            if (state_q == S_HOLD) begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    alpha_d = 8'd0;
                    if (hold_only) begin
                        idx_d = nxt;
                        {red_d, green_d, blue_d} = pal_b;
                        upd_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end else begin
                upd_d = 1'b1;
                if (alpha_q == 8'hFF) begin
                    alpha_d = 8'd0;
                    idx_d   = nxt;
                    {red_d, green_d, blue_d} = pal_b;
                end else begin
                    alpha_d = alpha_inc;
                    red_d   = mix(pal_a[23:16], pal_b[23:16], alpha_inc);
                    green_d = mix(pal_a[15:8],  pal_b[15:8],  alpha_inc);
                    blue_d  = mix(pal_a[7:0],   pal_b[7:0],   alpha_inc);
                end
            end
        end
    end

    assign red_lvl   = red_q;
    assign green_lvl = green_q;
    assign blue_lvl  = blue_q;
    assign color_idx = idx_q;
    assign lvl_upd   = upd_q;

endmodule

// File: doc/rgb_fade_seq.md
Name: rgb_fade_seq

Overview:
Colour-sequence generator that sits directly upstream of the tri-colour LED PWM stage. It steps through a fixed 7-entry palette and linearly crossfades between consecutive entries. It emits registered 8-bit red/green/blue duty levels plus an update strobe, which the PWM stage compares against its carrier counter. A hold-only mode replaces the crossfade with hard colour jumps.

Parameters:
STEP_DIV, 390625, clk100mhz cycles per step tick (256 ticks = 1 s at 100 MHz); minimum 2.
HOLD_STEPS, 256, number of step ticks a palette colour is held before the transition starts; minimum 1.

Ports:
clk100mhz  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset; asserting it (low) resets immediately, deassertion is sampled by clk100mhz
enable  in  1  1 = run; 0 = freeze all state and outputs
hold_only  in  1  1 = jump mode (no crossfade); sampled when HOLD ends
skip  in  1  single-cycle pulse: advance to the next colour immediately
red_lvl  out  8  red duty level
green_lvl  out  8  green duty level
blue_lvl  out  8  blue duty level
color_idx  out  3  current (source) palette index, 0..6
lvl_upd  out  1  one-cycle pulse on every edge that writes the level registers

Behaviour:
- Palette (R,G,B), fixed: 0=(255,0,0) 1=(255,128,0) 2=(255,255,0) 3=(0,255,0) 4=(0,0,255) 5=(102,0,255) 6=(128,0,128). next(i) = i+1, with 6 wrapping to 0.
- Reset values: red_lvl=255, green_lvl=0, blue_lvl=0, color_idx=0, lvl_upd=0, state=HOLD, prescaler=0, hold count=0, alpha=0.
- Prescaler counts 0..STEP_DIV-1 while enable=1. Tick = prescaler at STEP_DIV-1; the tick's actions take effect on that same edge, and the prescaler wraps to 0. The first tick after reset occurs at the STEP_DIV-th enabled edge.
- States:
  - HOLD: count ticks. On the HOLD_STEPS-th tick, clear the hold count, then:
    - hold_only=0: go to FADE with alpha=0; levels unchanged, no lvl_upd.
    - hold_only=1: color_idx<=next, levels<=palette[next], lvl_upd=1, stay in HOLD.
  - FADE: each tick increments alpha (8 bit).
    - For alpha=1..255, each channel <= (A*(256-alpha) + B*alpha) >> 8, with A=palette[color_idx], B=palette[next]. Use unsigned 17-bit intermediates and truncate, no rounding. lvl_upd=1.
    - The tick with alpha=255 (256th FADE tick) does not compute: levels <= B exactly, color_idx<=next, alpha<=0, state<=HOLD, lvl_upd=1.
- lvl_upd is registered, high for exactly the cycle after the writing edge, and coincides with the new level values. It pulses even when a channel value is unchanged.
- skip (enable=1, any state):
  - color_idx<=next, levels<=palette[next], lvl_upd=1, state<=HOLD.
  - Hold count, alpha and prescaler cleared.
  - skip wins over a coincident tick.
  - skip while enable=0 is ignored, not queued.
- enable=0: prescaler, counters, alpha, state, levels and color_idx all hold; lvl_upd=0. On re-enable, counting resumes from the frozen values.
- Reset mid-FADE: outputs take their reset values asynchronously, without waiting for a clock edge.

Test Plan:
Use STEP_DIV=4 and HOLD_STEPS=3 unless noted.
1. Reset release, enable=1, hold_only=0 -> levels 255/0/0, idx 0, no lvl_upd through edge 12 (FADE entered); first lvl_upd after edge 16, green=0 ((128*1)>>8); after the 128th FADE tick green=64, red=255.
2. Full fade 0->1 -> exactly 256 lvl_upd pulses in FADE; final levels 255/128/0, idx=1; next FADE starts 12 clocks later.
3. Wrap 6->0, using skip pulses to reach idx 6 -> after 256 FADE ticks levels 255/0/0, idx=0; at alpha=128: red=191, blue=64.
4. skip at FADE alpha=100 from idx 2 -> next cycle levels 0/255/0, idx=3, single lvl_upd, HOLD restarts (next FADE entry exactly 12 enabled clocks later); skip coincident with a tick produces one update only.
5. enable=0 for 50 cycles mid-FADE -> outputs constant, lvl_upd=0 throughout; after re-enable the first update shows alpha+1 relative to the frozen alpha.
6. hold_only=1 -> idx increments every 12 clocks with one lvl_upd each and no intermediate levels; rst driven low mid-FADE -> outputs 255/0/0 and idx 0 before the next clock edge.
